// File: rtl/demux8_deser.sv
// Registered 1-to-8 demultiplexer / serial-to-parallel deserializer.
// Bits are steered by address (load) or by an auto-incrementing position (shift).
module demux8_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic [2:0] s,
  input  logic       load,
  input  logic       shift,
  input  logic       clr,
  input  logic       out_ready,
  output logic [7:0] q,
  output logic       out_valid,
  output logic [2:0] cnt,
  output logic       overrun,
  output logic [7:0] shadow_q
);

  logic [7:0] shadow_reg, shadow_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] q_reg, q_next;
  logic       valid_reg, valid_next;
  logic       overrun_reg, overrun_next;
  logic       complete;
  logic       accept;

  // A clr cycle suppresses the shift, so it can never complete a word.
  assign complete = shift && !clr && (cnt_reg == 3'd7);
  assign accept   = valid_reg && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      always_comb begin
        shadow_next[gi] = shadow_reg[gi];
        if (clr) begin
          shadow_next[gi] = 1'b0;
        end else if (shift) begin
          if (cnt_reg == 3'(gi)) shadow_next[gi] = d;
        end else if (load && (s == 3'(gi))) begin
          shadow_next[gi] = d;
        end
      end
    end
  endgenerate

  always_comb begin
    cnt_next     = cnt_reg;
    q_next       = q_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (clr) begin
      cnt_next     = 3'd0;
      overrun_next = 1'b0;
    end else if (shift) begin
      cnt_next = cnt_reg + 3'd1;
    end
    if (complete) begin
      // The completing bit goes straight into q; shadow[7] is updated in parallel.
      q_next     = {d, shadow_reg[6:0]};
      valid_next = 1'b1;
      if (valid_reg && !out_ready) overrun_next = 1'b1;
    end else if (accept) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg  <= 8'h00;
      cnt_reg     <= 3'd0;
      q_reg       <= 8'h00;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      shadow_reg  <= shadow_next;
      cnt_reg     <= cnt_next;
      q_reg       <= q_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign q         = q_reg;
  assign out_valid = valid_reg;
  assign cnt       = cnt_reg;
  assign overrun   = overrun_reg;
  assign shadow_q  = shadow_reg;

endmodule

// File: tb/tb_demux8_deser.sv
// Bench for demux8_deser: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_demux8_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d = 1'b0;
  logic [2:0] s = 3'd0;
  logic       load = 1'b0;
  logic       shift = 1'b0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] q;
  logic       out_valid;
  logic [2:0] cnt;
  logic       overrun;
  logic [7:0] shadow_q;

  demux8_deser dut (
    .clk(clk), .rst(rst), .d(d), .s(s), .load(load), .shift(shift), .clr(clr),
    .out_ready(out_ready), .q(q), .out_valid(out_valid), .cnt(cnt),
    .overrun(overrun), .shadow_q(shadow_q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: bit array for the assembly register, integer position.
  bit       m_bits[8];
  int       m_pos;
  bit [7:0] m_q;
  bit       m_valid;
  bit       m_ovr;

  function automatic bit [7:0] m_shadow();
    bit [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_bits[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit sh, input bit ld,
                            input bit dd, input int ss, input bit rdy);
    bit [7:0] word;
    bit       was_valid;
    if (r) begin
      for (int i = 0; i < 8; i++) m_bits[i] = 0;
      m_pos = 0; m_q = 0; m_valid = 0; m_ovr = 0;
      return;
    end
    was_valid = m_valid;
    if (was_valid && rdy) m_valid = 0;
    if (c) begin
      for (int i = 0; i < 8; i++) m_bits[i] = 0;
      m_pos = 0; m_ovr = 0;
    end else if (sh) begin
      m_bits[m_pos] = dd;
      if (m_pos == 7) begin
        word = m_shadow();
        if (was_valid && !rdy) m_ovr = 1;
        m_q = word;
        m_valid = 1;
      end
      m_pos = (m_pos + 1) % 8;
    end else if (ld) begin
      m_bits[ss] = dd;
    end
  endtask

  task automatic step(input bit r, input bit c, input bit sh, input bit ld,
                      input bit dd, input int ss, input bit rdy);
    rst = r; clr = c; shift = sh; load = ld; d = dd; s = 3'(ss); out_ready = rdy;
    @(posedge clk);
    model_step(r, c, sh, ld, dd, ss, rdy);
    #1;
  endtask

  task automatic shift_word(input bit [7:0] w, input bit rdy);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, w[i], 0, rdy);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("q", q, m_q);
      chk("out_valid", out_valid, m_valid);
      chk("cnt", cnt, m_pos);
      chk("overrun", overrun, m_ovr);
      chk("shadow_q", shadow_q, m_shadow());
    end
  end

  initial begin
    bit [7:0] seq1;
    #1;
    step(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_q", q, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_cnt", cnt, 3'd0);
    chk("rst_shadow", shadow_q, 8'h00);

    // Serial word 1,0,1,1,0,0,1,0 (first bit lands in bit 0)
    seq1 = 8'b0100_1101;
    shift_word(seq1, 0);
    chk("word_q", q, 8'h4D);
    chk("word_valid", out_valid, 1'b1);
    chk("word_cnt", cnt, 3'd0);
    chk("word_ovr", overrun, 1'b0);

    // Addressed writes
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 3, 0);
    step(0, 0, 0, 1, 1, 7, 0);
    chk("load_shadow", shadow_q, 8'h88);
    chk("load_cnt", cnt, 3'd0);
    chk("load_valid", out_valid, 1'b0);

    // Back-to-back words with consumer always ready
    step(1, 0, 0, 0, 0, 0, 0);
    shift_word(8'hA5, 1);
    chk("b2b_q0", q, 8'hA5);
    chk("b2b_v0", out_valid, 1'b1);
    shift_word(8'h3C, 1);
    chk("b2b_q1", q, 8'h3C);
    chk("b2b_v1", out_valid, 1'b1);
    chk("b2b_ovr", overrun, 1'b0);

    // Overrun and clr retention
    step(1, 0, 0, 0, 0, 0, 0);
    shift_word(8'hFF, 0);
    shift_word(8'h01, 0);
    chk("ovr_q", q, 8'h01);
    chk("ovr_set", overrun, 1'b1);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("clr_ovr", overrun, 1'b0);
    chk("clr_q", q, 8'h01);
    chk("clr_valid", out_valid, 1'b1);

    // shift beats load in the same cycle
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 5, 0);
    chk("prio_shadow", shadow_q, 8'h04);
    chk("prio_cnt", cnt, 3'd3);

    // Completion coinciding with an accept
    step(1, 0, 0, 0, 0, 0, 0);
    shift_word(8'h11, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 1);
    chk("acc_q", q, 8'h80);
    chk("acc_valid", out_valid, 1'b1);
    chk("acc_ovr", overrun, 1'b0);

    // Reset mid-word
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("mid_cnt", cnt, 3'd0);
    chk("mid_shadow", shadow_q, 8'h00);
    chk("mid_valid", out_valid, 1'b0);
    shift_word(8'h5A, 0);
    chk("mid_word", q, 8'h5A);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
           1'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
